// File: rtl/adc_spi_master.sv
// SPI master for the serial ADC front end of the LED-strip DSP chain.
// One frame per accepted start: sends start bit, SGL/DIFF and a 3-bit channel,
// then shifts back the null bit and a 10-bit sample (MSB first).
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   start               conversion request, sampled in IDLE only
//   channel, single_ended  command fields, latched when start is accepted
//   busy                high from accepted start until the cs-high gap ends
//   cs, sclk, mosi      ADC pins (cs active low, sclk idles low)
//   miso                ADC data out
//   sample, sample_channel, null_err  result of the last completed frame
//   sample_valid        one-clk pulse when the result registers update
module adc_spi_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_IDLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] channel,
    input  logic       single_ended,
    output logic       busy,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [9:0] sample,
    output logic [2:0] sample_channel,
    output logic       sample_valid,
    output logic       null_err
);

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned EDGE_W    = 5;
    localparam int unsigned SMP_W     = 10;
    localparam int unsigned GAP_LEN   = CS_IDLE * CLK_DIV;
    localparam int unsigned LAST_EDGE = 16;
    localparam int unsigned NULL_EDGE = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_END,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;      // index of the next sclk rising edge
    logic [2:0]         ch_q, ch_d;
    logic               sgl_q, sgl_d;
    logic [SMP_W-1:0]   shift_q, shift_d;
    logic               null_q, null_d;
    logic               busy_q, busy_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [SMP_W-1:0]   sample_q, sample_d;
    logic [2:0]         smp_ch_q, smp_ch_d;
    logic               valid_q, valid_d;
    logic               null_err_q, null_err_d;

    logic               half_done_c;
    logic               gap_done_c;
    logic               cmd_bit_c;

    assign half_done_c = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign gap_done_c  = (cnt_q == CNT_W'(GAP_LEN - 1));

    // Command bit to present for the upcoming rising edge (edge 0 is set on accept).
    always_comb begin
        cmd_bit_c = 1'b0;
        case (edge_q)
            EDGE_W'(1): cmd_bit_c = sgl_q;
            EDGE_W'(2): cmd_bit_c = ch_q[2];
            EDGE_W'(3): cmd_bit_c = ch_q[1];
            EDGE_W'(4): cmd_bit_c = ch_q[0];
            default:    cmd_bit_c = 1'b0;
        endcase
    end

    // Frame sequencing and pin/result next-state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        ch_d       = ch_q;
        sgl_d      = sgl_q;
        shift_d    = shift_q;
        null_d     = null_q;
        busy_d     = busy_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        sample_d   = sample_q;
        smp_ch_d   = smp_ch_q;
        valid_d    = 1'b0;
        null_err_d = null_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    mosi_d  = 1'b1;
                    ch_d    = channel;
                    sgl_d   = single_ended;
                    cnt_d   = '0;
                    edge_d  = '0;
                end
            end
            S_SETUP: begin
                if (half_done_c) begin
                    // Rising edge 0 carries the start bit; miso is ignored here.
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    edge_d  = EDGE_W'(1);
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (half_done_c) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        if (edge_q == EDGE_W'(NULL_EDGE)) begin
                            null_d = miso;
                        end else if (edge_q > EDGE_W'(NULL_EDGE)) begin
                            shift_d = {shift_q[SMP_W-2:0], miso};
                        end
                        if (edge_q == EDGE_W'(LAST_EDGE)) begin
                            state_d = S_END;
                        end else begin
                            edge_d = edge_q + EDGE_W'(1);
                        end
                    end else begin
                        mosi_d = cmd_bit_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_END: begin
                // Final half-period after edge 16; sclk and cs return to idle together.
                if (half_done_c) begin
                    cnt_d      = '0;
                    sclk_d     = 1'b0;
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    sample_d   = shift_q;
                    smp_ch_d   = ch_q;
                    null_err_d = null_q;
                    valid_d    = 1'b1;
                    state_d    = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_done_c) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            ch_q       <= '0;
            sgl_q      <= 1'b0;
            shift_q    <= '0;
            null_q     <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            sample_q   <= '0;
            smp_ch_q   <= '0;
            valid_q    <= 1'b0;
            null_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            ch_q       <= ch_d;
            sgl_q      <= sgl_d;
            shift_q    <= shift_d;
            null_q     <= null_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            sample_q   <= sample_d;
            smp_ch_q   <= smp_ch_d;
            valid_q    <= valid_d;
            null_err_q <= null_err_d;
        end
    end

    assign busy           = busy_q;
    assign cs             = cs_q;
    assign sclk           = sclk_q;
    assign mosi           = mosi_q;
    assign sample         = sample_q;
    assign sample_channel = smp_ch_q;
    assign sample_valid   = valid_q;
    assign null_err       = null_err_q;

endmodule
